twiddle_factor_generator: RTL and testbench

Per-stage twiddle-factor distributor for the D-lane radix-2 NTT/INTT datapath. It takes a table of D forward twiddle powers and a table of D inverse twiddle powers. For the selected transform direction and butterfly stage, it drives one twiddle value to each of the D lanes, so both members of every butterfly pair see the same factor. The output is registered once and feeds the butterfly array directly.

---
 rtl/twiddle_factor_generator_if.sv | 17 +
 rtl/twiddle_factor_generator.sv | 51 +++++
 tb/tb_twiddle_factor_generator.sv | 117 +++++++++++
 3 files changed

// File: rtl/twiddle_factor_generator_if.sv
// Bundle between the twiddle tables / stage control and the butterfly-array twiddle bus.
// The master drives the tables and selection; the slave returns the registered per-lane factors.
interface twiddle_factor_generator_if #(
    parameter int N = 17,
    parameter int D = 8
);
    localparam int SW = $clog2($clog2(D));

    logic [N*D-1:0] tf_in;
    logic [N*D-1:0] tf_in_inv;
    logic           inv;
    logic [SW-1:0]  stage;
    logic [N*D-1:0] tf;

    modport master (output tf_in, output tf_in_inv, output inv, output stage, input tf);
    modport slave  (input tf_in, input tf_in_inv, input inv, input stage, output tf);
endinterface

// File: rtl/twiddle_factor_generator.sv
// Per-stage twiddle distributor: routes one table entry to every lane for the chosen
// stage and direction, so both inputs of each butterfly see the same factor.
module twiddle_factor_generator #(
    parameter int N = 17,
    parameter int D = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    twiddle_factor_generator_if.slave bus
);
    localparam int SW    = $clog2($clog2(D));
    localparam int LOG_D = $clog2(D);
    localparam int IDX_W = $clog2(D);

    logic [N*D-1:0] src;
    logic [N*D-1:0] next_tf;
    logic [N*D-1:0] tf_p1;

    // Table lane feeding output lane 'lane'; out-of-range stages fall back to lane 0.
    function automatic logic [IDX_W-1:0] lane_sel(input int lane, input logic [SW-1:0] s);
        int half;
        int span;
        int e;
        e = 0;
        if (int'(s) < LOG_D) begin
            half = 1 << s;
            span = half * 2;
            e    = ((lane % span) % half) * (D / span);
        end
        return IDX_W'(e);
    endfunction

    always_comb begin
        src     = bus.inv ? bus.tf_in_inv : bus.tf_in;
        next_tf = '0;
        for (int i = 0; i < D; i++) begin
            next_tf[i*N +: N] = src[int'(lane_sel(i, bus.stage))*N +: N];
        end
    end

    // Stage boundary: lane mux result -> registered twiddle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_p1 <= '0;
        end else begin
            tf_p1 <= next_tf;
        end
    end

    assign bus.tf = tf_p1;
endmodule

// File: tb/tb_twiddle_factor_generator.sv
// Directed scoreboard bench for twiddle_factor_generator with N=17, D=8.
module tb_twiddle_factor_generator;
    localparam int N     = 17;
    localparam int D     = 8;
    localparam int LOG_D = 3;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    twiddle_factor_generator_if #(.N(N), .D(D)) bus ();

    twiddle_factor_generator #(.N(N), .D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int passes = 0;
    logic [N*D-1:0] exp_q[$];
    logic [N*D-1:0] last_exp;

    // Expected lane value: base (100 fwd / 200 inv) plus the twiddle exponent.
    function automatic logic [N*D-1:0] model(input logic iv, input int s);
        logic [N*D-1:0] r;
        int e;
        r = '0;
        for (int i = 0; i < D; i++) begin
            if (s >= LOG_D) e = 0;
            else            e = (i & ((1 << s) - 1)) << (LOG_D - 1 - s);
            r[i*N +: N] = N'((iv ? 200 : 100) + e);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [N*D-1:0] obs, input logic [N*D-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s got=%h want=%h", tag, obs, exp);
    endtask

    // Lower lanes carry the documented values; upper lanes get fresh garbage each call.
    task automatic load_tables();
        for (int k = 0; k < D; k++) begin
            if (k < D/2) begin
                bus.tf_in[k*N +: N]     = N'(100 + k);
                bus.tf_in_inv[k*N +: N] = N'(200 + k);
            end else begin
                bus.tf_in[k*N +: N]     = N'($urandom);
                bus.tf_in_inv[k*N +: N] = N'($urandom);
            end
        end
    endtask

    task automatic step(input logic iv, input int s);
        load_tables();
        bus.inv   = iv;
        bus.stage = SW'(s);
        exp_q.push_back(model(iv, s));
        #1;
        check($sformatf("hold_before_inv%0d_s%0d", iv, s), bus.tf, last_exp);
        @(posedge clk);
        #1;
        last_exp = exp_q.pop_front();
        check($sformatf("inv%0d_s%0d", iv, s), bus.tf, last_exp);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.tf_in     = {4{$urandom}};
        bus.tf_in_inv = {4{$urandom}};
        bus.inv       = 1'b1;
        bus.stage     = 2'd2;
        last_exp      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", bus.tf, '0);

        @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, 0);
        step(1'b0, 1);
        step(1'b0, 2);
        step(1'b1, 2);
        step(1'b1, 3);
        step(1'b0, 3);

        // Change direction and stage together on every cycle.
        for (int c = 0; c < 8; c++) begin
            step(logic'(c & 1), (c * 3) & 3);
        end

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_midcycle", bus.tf, '0);
        load_tables();
        bus.inv   = 1'b0;
        bus.stage = 2'd2;
        @(posedge clk);
        #1;
        check("reset_overrides_edge", bus.tf, '0);
        exp_q.delete();
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1);
        step(1'b0, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
